blit_cmd_seq: RTL and testbench
===============================

Name: blit_cmd_seq

Overview:
- Queued blitter command sequencer; a parametrised successor to the blitter state block.
- Accepts command/count pairs from the GPU bus into a DEPTH-entry FIFO, so software can queue blits back-to-back.
- Runs the outer loop itself: issues an inner-loop start per outer iteration, counts down the outer count and pulses address-update strobes.
- Sits between the GPU register decode and the existing inner-loop/address/data control units; reports status on the GPU read bus.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, 2..16).
- ICNT_W, 16, inner count width.
- OCNT_W, 16, outer count width (ICNT_W+OCNT_W <= 32).

Ports:
- sys_clk  in  1  system clock; all state updates on rising edge.
- xreset_n  in  1  asynchronous active-low reset.
- gpu_din  in  32  GPU write data.
- cmdld  in  1  push {cmd=gpu_din, staged count} into FIFO.
- countld  in  1  stage count word: inner=gpu_din[ICNT_W-1:0], outer=gpu_din[16+OCNT_W-1:16].
- stopld  in  1  control write; gpu_din[0]=1 requests abort.
- statrd  in  1  status read strobe.
- indone  in  1  inner-loop-complete pulse from inner unit.
- cmd_out  out  32  current command word.
- icount_out  out  ICNT_W  inner count for current command.
- cmd_strobe  out  1  one-cycle pulse: cmd_out/icount_out newly valid.
- instart  out  1  one-cycle inner-loop start pulse.
- a_update  out  1  one-cycle pulse after each inner loop except the last.
- active  out  1  high from LOAD through DONE.
- blit_int  out  1  one-cycle completion interrupt.
- gpu_dout  out  32  status word.
- gpu_dout_oe  out  1  equals statrd.
- perf_dout  out  32  busy-cycle counter (optional feature).

Behaviour:
- Reset values: all outputs 0; FIFO empty; staged count 0; overflow and aborted flags 0; state IDLE.
- FIFO push on cmdld: entry visible the next cycle.
  - Push when full: entry dropped, overflow flag set.
  - Push and pop in the same cycle while full: push accepted.
- States: IDLE, LOAD, INNER, WAIT, OUTER, DONE.
- IDLE: FIFO non-empty -> LOAD.
- LOAD (1 cycle): pop the FIFO head; drive cmd_out and icount_out; pulse cmd_strobe; load outer remaining (0 means 2^OCNT_W).
  - Inner count 0 -> DONE; otherwise -> INNER.
- INNER (1 cycle): pulse instart -> WAIT.
- WAIT: hold until indone, then -> OUTER.
- OUTER (1 cycle): outer remaining -= 1.
  - If the result is 0 -> DONE.
  - Otherwise pulse a_update -> INNER.
- DONE (1 cycle): pulse blit_int if cmd_out[31]=1.
  - FIFO non-empty -> LOAD; else -> IDLE.
- Minimum latency: cmdld in cycle N into an empty idle unit gives LOAD at N+2 and instart at N+3.
- indone outside WAIT is ignored.
- Abort (stopld with gpu_din[0]=1):
  - Next cycle: FIFO flushed, state IDLE, all pulses suppressed, aborted flag set.
  - cmdld in the same cycle as the abort is discarded and does not set overflow.
  - A later cmdld clears the aborted flag.
- Status word on gpu_dout:
  - [0] idle (IDLE and FIFO empty); [1] FIFO full; [2] overflow; [3] aborted; [8:4] FIFO level.
  - [15:9] zero; [31:16] outer remaining, zero-extended when OCNT_W<16.
  - gpu_dout_oe=statrd.
- statrd clears the overflow flag in the cycle after the read.
- Reset asserted mid-operation: immediate return to reset values; pulses are never held across reset.

Optional Feature:
- Macro: BLIT_CMD_SEQ_PERF_EN.
- With the macro: perf_dout is a 32-bit counter incremented every cycle active=1. It saturates at 0xFFFFFFFF and is cleared by stopld with gpu_din[1]=1.
- Without the macro: perf_dout is constant 0 and no counter logic is built.

Test Plan:
- countld 0x0003_0010, then cmdld 0x8000_0000, indone 5 cycles after each instart -> icount_out=0x10; 3 instart, 2 a_update, 1 blit_int; status reads idle=1 afterwards.
- Queue 4 commands (DEPTH=4) while running, then a 5th cmdld -> status[1]=1 and [2]=1; exactly 4 blit_int pulses at completion; first statrd returns overflow=1, second returns 0.
- Outer count 0 with inner 1 (OCNT_W=4) -> 16 instart pulses before DONE.
- Inner count 0 with cmd[31]=1 -> cmd_strobe then blit_int two cycles later, no instart.
- Abort in WAIT with 2 entries queued -> next cycle active=0, level 0, status[3]=1; later indone produces no pulses.
- Perf feature on: 3-outer blit with indone latency 5 -> perf_dout equals the counted active cycles; stopld 0x2 clears it to 0.

Source files
------------

// File: rtl/blit_cmd_seq.sv
// Queued blitter command sequencer: DEPTH-entry command FIFO feeding an outer-loop FSM.
// Optional busy-cycle counter on perf_dout is built only when BLIT_CMD_SEQ_PERF_EN is defined.
module blit_cmd_seq #(
  parameter int DEPTH  = 4,
  parameter int ICNT_W = 16,
  parameter int OCNT_W = 16
) (
  input  logic              sys_clk,
  input  logic              xreset_n,
  input  logic [31:0]       gpu_din,
  input  logic              cmdld,
  input  logic              countld,
  input  logic              stopld,
  input  logic              statrd,
  input  logic              indone,
  output logic [31:0]       cmd_out,
  output logic [ICNT_W-1:0] icount_out,
  output logic              cmd_strobe,
  output logic              instart,
  output logic              a_update,
  output logic              active,
  output logic              blit_int,
  output logic [31:0]       gpu_dout,
  output logic              gpu_dout_oe,
  output logic [31:0]       perf_dout,
  output logic [2:0]        dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_INNER = 3'd2,
    S_WAIT  = 3'd3,
    S_OUTER = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state;
  logic [31:0]       cmd_mem  [DEPTH];
  logic [ICNT_W-1:0] icnt_mem [DEPTH];
  logic [OCNT_W-1:0] ocnt_mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic [ICNT_W-1:0] stage_icnt;
  logic [OCNT_W-1:0] stage_ocnt, outer_rem;
  logic              overflow, aborted;
  logic              abort, fifo_empty, fifo_full, pop, push, idle;

  assign abort      = stopld & gpu_din[0];
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LW'(DEPTH));
  // The head is consumed on the edge that enters LOAD; a full FIFO may accept a push on that edge.
  assign pop        = !abort && !fifo_empty && ((state == S_IDLE) || (state == S_DONE));
  assign push       = cmdld && !abort && (!fifo_full || pop);
  assign idle       = (state == S_IDLE) && fifo_empty;
  assign dbg_state  = state;

  always_ff @(posedge sys_clk) begin
    if (push) begin
      cmd_mem[wr_ptr]  <= gpu_din;
      icnt_mem[wr_ptr] <= stage_icnt;
      ocnt_mem[wr_ptr] <= stage_ocnt;
    end
  end

  always_ff @(posedge sys_clk or negedge xreset_n) begin
    if (!xreset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      stage_icnt <= '0;
      stage_ocnt <= '0;
      overflow   <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      if (countld) begin
        stage_icnt <= gpu_din[ICNT_W-1:0];
        stage_ocnt <= gpu_din[16+OCNT_W-1:16];
      end
      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      level <= level + LW'(1);
        else if (pop && !push) level <= level - LW'(1);
      end
      if (cmdld && !abort && fifo_full && !pop) overflow <= 1'b1;
      else if (statrd)                          overflow <= 1'b0;
      if (abort)      aborted <= 1'b1;
      else if (cmdld) aborted <= 1'b0;
    end
  end

  // cmd_strobe qualifies cmd_out/icount_out for exactly one cycle; downstream units sample
  // them on that cycle and there is no back-pressure. instart/indone pair the same way.
  always_ff @(posedge sys_clk or negedge xreset_n) begin
    if (!xreset_n) begin
      state      <= S_IDLE;
      cmd_out    <= '0;
      icount_out <= '0;
      outer_rem  <= '0;
      cmd_strobe <= 1'b0;
      instart    <= 1'b0;
      a_update   <= 1'b0;
      active     <= 1'b0;
      blit_int   <= 1'b0;
    end else begin
      cmd_strobe <= 1'b0;
      instart    <= 1'b0;
      a_update   <= 1'b0;
      blit_int   <= 1'b0;
      if (abort) begin
        state  <= S_IDLE;
        active <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (pop) begin
              state      <= S_LOAD;
              cmd_out    <= cmd_mem[rd_ptr];
              icount_out <= icnt_mem[rd_ptr];
              outer_rem  <= ocnt_mem[rd_ptr];
              cmd_strobe <= 1'b1;
              active     <= 1'b1;
            end
          end
          S_LOAD: begin
            if (icount_out == '0) begin
              state <= S_DONE;
            end else begin
              state   <= S_INNER;
              instart <= 1'b1;
            end
          end
          S_INNER: state <= S_WAIT;
          S_WAIT: begin
            if (indone) begin
              state     <= S_OUTER;
              outer_rem <= outer_rem - OCNT_W'(1);
              a_update  <= (outer_rem != OCNT_W'(1));
            end
          end
          S_OUTER: begin
            if (outer_rem == '0) begin
              state <= S_DONE;
            end else begin
              state   <= S_INNER;
              instart <= 1'b1;
            end
          end
          S_DONE: begin
            blit_int <= cmd_out[31];
            if (pop) begin
              state      <= S_LOAD;
              cmd_out    <= cmd_mem[rd_ptr];
              icount_out <= icnt_mem[rd_ptr];
              outer_rem  <= ocnt_mem[rd_ptr];
              cmd_strobe <= 1'b1;
            end else begin
              state  <= S_IDLE;
              active <= 1'b0;
            end
          end
          default: begin
            state  <= S_IDLE;
            active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign gpu_dout_oe = statrd;
  assign gpu_dout    = statrd ? {16'(outer_rem), 7'd0, 5'(level), aborted, overflow, fifo_full, idle}
                              : 32'd0;

`ifdef BLIT_CMD_SEQ_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge sys_clk or negedge xreset_n) begin
    if (!xreset_n)                    perf_cnt <= '0;
    else if (stopld && gpu_din[1])    perf_cnt <= '0;
    else if (active && perf_cnt != '1) perf_cnt <= perf_cnt + 32'd1;
  end

  assign perf_dout = perf_cnt;
`else
  assign perf_dout = 32'd0;
`endif

endmodule

// File: tb/tb_blit_cmd_seq.sv
// Directed bench for blit_cmd_seq: scoreboard of issued commands, pulse counters, status reads.
module tb_blit_cmd_seq;

  logic        sys_clk = 1'b0;
  logic        xreset_n;
  logic [31:0] gpu_din;
  logic        cmdld, countld, stopld, statrd, indone;
  logic [31:0] cmd_out;
  logic [15:0] icount_out;
  logic        cmd_strobe, instart, a_update, active, blit_int;
  logic [31:0] gpu_dout;
  logic        gpu_dout_oe;
  logic [31:0] perf_dout;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_instart = 0, n_aupd = 0, n_bint = 0, n_strobe = 0, n_active = 0;
  logic [47:0] exp_q[$];
  logic [47:0] mon_exp;
  logic [15:0] m_icnt = '0;

  blit_cmd_seq #(.DEPTH(4), .ICNT_W(16), .OCNT_W(4)) dut (
    .sys_clk(sys_clk), .xreset_n(xreset_n), .gpu_din(gpu_din), .cmdld(cmdld),
    .countld(countld), .stopld(stopld), .statrd(statrd), .indone(indone),
    .cmd_out(cmd_out), .icount_out(icount_out), .cmd_strobe(cmd_strobe),
    .instart(instart), .a_update(a_update), .active(active), .blit_int(blit_int),
    .gpu_dout(gpu_dout), .gpu_dout_oe(gpu_dout_oe), .perf_dout(perf_dout),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // inner-loop unit model: indone 5 cycles after every instart
  initial begin
    indone = 1'b0;
    forever begin
      @(negedge sys_clk);
      indone = 1'b0;
      if (instart === 1'b1) begin
        repeat (5) @(negedge sys_clk);
        indone = 1'b1;
      end
    end
  end

  // monitor + scoreboard
  always @(negedge sys_clk) begin
    if (xreset_n) begin
      if (instart)  n_instart++;
      if (a_update) n_aupd++;
      if (blit_int) n_bint++;
      if (active)   n_active++;
      if (cmd_strobe) begin
        n_strobe++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_cmd", {16'd0, cmd_out, icount_out}, 64'hDEAD);
        end else begin
          mon_exp = exp_q.pop_front();
          check("sb_cmd", {16'd0, cmd_out, icount_out}, {16'd0, mon_exp});
        end
      end
    end
  end

  // driver tasks (all start and end on a falling edge)
  task automatic do_countld(input logic [31:0] d);
    gpu_din = d; countld = 1'b1; m_icnt = d[15:0];
    @(negedge sys_clk);
    countld = 1'b0; gpu_din = '0;
  endtask

  task automatic do_cmdld(input logic [31:0] d, input bit accept);
    gpu_din = d; cmdld = 1'b1;
    if (accept) exp_q.push_back({d, m_icnt});
    @(negedge sys_clk);
    cmdld = 1'b0; gpu_din = '0;
  endtask

  task automatic read_status(output logic [31:0] st);
    statrd = 1'b1;
    #1;
    st = gpu_dout;
    check("dout_oe", gpu_dout_oe, 1);
    @(negedge sys_clk);
    statrd = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int run = 0;
    int n = 0;
    while (run < 2 && n < budget) begin
      @(negedge sys_clk);
      n++;
      if (dbg_state == 3'd0 && !active) run++;
      else run = 0;
    end
    check(tag, run >= 2, 1);
  endtask

  initial begin
    logic [31:0] st;
    int s_inst, s_aupd, s_bint, s_strobe, s_act;
    xreset_n = 1'b0; gpu_din = '0; cmdld = 0; countld = 0; stopld = 0; statrd = 0;
    repeat (3) @(negedge sys_clk);
    check("rst_cmd_out", cmd_out, 0);
    check("rst_icount", icount_out, 0);
    check("rst_pulses", {cmd_strobe, instart, a_update, blit_int}, 0);
    check("rst_active", active, 0);
    check("rst_dout", {gpu_dout_oe, gpu_dout}, 0);
    check("rst_perf", perf_dout, 0);
    xreset_n = 1'b1;
    @(negedge sys_clk);
    read_status(st);
    check("rst_status", st, 32'h0000_0001);

    // basic 3-outer blit with latency checks
    s_inst = n_instart; s_aupd = n_aupd; s_bint = n_bint; s_act = n_active;
    do_countld(32'h0003_0010);
    do_cmdld(32'h8000_0000, 1);
    check("lat_n1_idle", dbg_state, 0);
    @(negedge sys_clk);
    check("lat_n2_strobe", cmd_strobe, 1);
    check("lat_n2_icount", icount_out, 16'h0010);
    @(negedge sys_clk);
    check("lat_n3_instart", instart, 1);
    wait_quiet("t1_timeout", 300);
    check("t1_instart", n_instart - s_inst, 3);
    check("t1_aupdate", n_aupd - s_aupd, 2);
    check("t1_blitint", n_bint - s_bint, 1);
    check("t1_active_cycles", n_active - s_act, 23);
`ifdef BLIT_CMD_SEQ_PERF_EN
    check("perf_count", perf_dout, 23);
`else
    check("perf_off", perf_dout, 0);
`endif
    gpu_din = 32'h2; stopld = 1'b1;
    @(negedge sys_clk);
    stopld = 1'b0; gpu_din = '0;
    check("perf_clear", perf_dout, 0);
    read_status(st);
    check("t1_status_idle", st, 32'h0000_0001);

    // zero inner count: no instart, blit_int two cycles after cmd_strobe
    s_inst = n_instart;
    do_countld(32'h0001_0000);
    do_cmdld(32'h8000_00AA, 1);
    @(negedge sys_clk);
    check("z_strobe", cmd_strobe, 1);
    @(negedge sys_clk);
    check("z_done_state", dbg_state, 5);
    check("z_bint_early", blit_int, 0);
    @(negedge sys_clk);
    check("z_bint", blit_int, 1);
    wait_quiet("z_timeout", 50);
    check("z_no_instart", n_instart - s_inst, 0);
    read_status(st);
    check("z_status", st, 32'h0001_0001);

    // queue full plus overflow
    s_inst = n_instart; s_bint = n_bint;
    do_countld(32'h0003_0001);
    do_cmdld(32'h0000_0A00, 1);
    for (int i = 1; i <= 4; i++) do_cmdld(32'h8000_0B00 | 32'(i), 1);
    do_cmdld(32'h8000_0F05, 0);
    read_status(st);
    check("ovf_status1", st & 32'h1FF, 32'h046);
    read_status(st);
    check("ovf_status2_bit2", st[2], 0);
    wait_quiet("ovf_timeout", 1000);
    check("ovf_blitint", n_bint - s_bint, 4);
    check("ovf_instart", n_instart - s_inst, 15);
    check("ovf_sb_empty", exp_q.size(), 0);

    // outer count 0 means 16 iterations with a 4-bit outer count
    s_inst = n_instart; s_aupd = n_aupd; s_bint = n_bint;
    do_countld(32'h0000_0001);
    do_cmdld(32'h0000_0055, 1);
    wait_quiet("o0_timeout", 500);
    check("o0_instart", n_instart - s_inst, 16);
    check("o0_aupdate", n_aupd - s_aupd, 15);
    check("o0_blitint", n_bint - s_bint, 0);

    // abort in WAIT with two queued, plus a discarded cmdld in the same cycle
    do_countld(32'h0002_0001);
    do_cmdld(32'h8000_0C01, 1);
    do_cmdld(32'h8000_0C02, 1);
    do_cmdld(32'h8000_0C03, 1);
    @(negedge sys_clk);
    check("ab_in_wait", dbg_state, 3);
    gpu_din = 32'h1; stopld = 1'b1; cmdld = 1'b1;
    @(negedge sys_clk);
    stopld = 1'b0; cmdld = 1'b0; gpu_din = '0;
    exp_q.delete();
    check("ab_active", active, 0);
    check("ab_state", dbg_state, 0);
    s_inst = n_instart; s_aupd = n_aupd; s_bint = n_bint; s_strobe = n_strobe; s_act = n_active;
    read_status(st);
    check("ab_status", st[15:0], 16'h0009);
    repeat (10) @(negedge sys_clk);
    check("ab_no_pulses", (n_instart - s_inst) + (n_aupd - s_aupd) + (n_bint - s_bint)
                          + (n_strobe - s_strobe) + (n_active - s_act), 0);
    do_countld(32'h0001_0000);
    do_cmdld(32'h0000_0001, 1);
    wait_quiet("ab_clr_timeout", 50);
    read_status(st);
    check("ab_cleared", st[3:0], 4'h1);

    // reset in the middle of a blit drops the instart pulse at once
    do_countld(32'h0002_0001);
    do_cmdld(32'h8000_0077, 1);
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("mr_instart_pre", instart, 1);
    xreset_n = 1'b0;
    #1;
    check("mr_instart", instart, 0);
    check("mr_active", active, 0);
    check("mr_cmd_out", cmd_out, 0);
    check("mr_state", dbg_state, 0);
    @(negedge sys_clk);
    xreset_n = 1'b1;
    check("mr_sb_empty", exp_q.size(), 0);
    repeat (10) @(negedge sys_clk);
    check("mr_stays_idle", {active, dbg_state}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
